// File: rtl/btn_debouncer_if.sv
// -----------------------------------------------------------------------------
// btn_debouncer_if
// Groups the button-side signals of btn_debouncer.
//   btns_raw      : raw asynchronous button levels, 1 = pressed
//   btns          : debounced levels (feeds btnInterpreter)
//   press_pulse   : one-cycle strobe per lane on an accepted 0->1 change
//   release_pulse : one-cycle strobe per lane on an accepted 1->0 change
//   any_held      : OR of btns
// Modports:
//   master : the side that supplies raw buttons and consumes clean outputs
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface btn_debouncer_if #(
  parameter int N_BTNS = 4
);
  logic [N_BTNS-1:0] btns_raw;
  logic [N_BTNS-1:0] btns;
  logic [N_BTNS-1:0] press_pulse;
  logic [N_BTNS-1:0] release_pulse;
  logic              any_held;

  modport master (
    output btns_raw,
    input  btns,
    input  press_pulse,
    input  release_pulse,
    input  any_held
  );

  modport slave (
    input  btns_raw,
    output btns,
    output press_pulse,
    output release_pulse,
    output any_held
  );
endinterface

// File: rtl/btn_debouncer.sv
// -----------------------------------------------------------------------------
// btn_debouncer
// Per-button two-flop synchroniser, stability-counter debouncer and edge
// detector. Every lane is identical and independent of the others.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous, active-high reset (clears every lane)
//   bus  : btn_debouncer_if.slave
//            btns_raw in, btns / press_pulse / release_pulse / any_held out
// Parameters:
//   N_BTNS          : number of lanes (must match the interface width)
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles before a new level is
//                     accepted, 1 .. 2^CNT_W-1
//   CNT_W           : width of each lane's stability counter
// Latency: with edge 1 being the first edge that samples a new steady raw
// level, btns changes after edge DEBOUNCE_CYCLES+2 and the matching strobe is
// high for the following cycle.
// -----------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BTNS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic            clk,
  input  logic            rst,
  btn_debouncer_if.slave  bus
);

  // Terminal count: acceptance happens on the edge where the counter already
  // holds DEBOUNCE_CYCLES-1, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,  // synchronised level agrees with the clean level
    ST_PENDING = 1'b1   // disagreement being timed
  } lane_state_e;

  logic [N_BTNS-1:0] btns_vec;
  logic [N_BTNS-1:0] press_vec;
  logic [N_BTNS-1:0] release_vec;

  for (genvar gi = 0; gi < N_BTNS; gi++) begin : g_lane
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             btns_q, btns_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lane_state_e      state;

    // Lane state is fully determined by the registered synchroniser output
    // and the registered clean level, so it needs no flop of its own.
    always_comb begin
      sync1_d   = bus.btns_raw[gi];
      sync2_d   = sync1_q;
      btns_d    = btns_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      cnt_d     = '0;
      state     = (sync2_q != btns_q) ? ST_PENDING : ST_STABLE;

      case (state)
        ST_STABLE: begin
          cnt_d = '0;
        end
        ST_PENDING: begin
          if (cnt_q == CNT_LAST) begin
            btns_d    = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        btns_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        btns_q    <= btns_d;
        press_q   <= press_d;
        release_q <= release_d;
        cnt_q     <= cnt_d;
      end
    end

    assign btns_vec[gi]    = btns_q;
    assign press_vec[gi]   = press_q;
    assign release_vec[gi] = release_q;
  end

  assign bus.btns          = btns_vec;
  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;
  // Derived only from registered levels, so it is glitch-free in practice.
  assign bus.any_held      = |btns_vec;

endmodule

// File: tb/tb_btn_debouncer.sv
// -----------------------------------------------------------------------------
// tb_btn_debouncer
// Two debouncer instances share one clock: dut_a with DEBOUNCE_CYCLES=4 and
// dut_b with DEBOUNCE_CYCLES=1. Each stimulus step drives one instance and
// pushes the outputs expected after the next rising edge into a scoreboard
// queue; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_btn_debouncer;

  logic clk;
  logic rst_a;
  logic rst_b;

  btn_debouncer_if #(.N_BTNS(4)) bus_a ();
  btn_debouncer_if #(.N_BTNS(4)) bus_b ();

  btn_debouncer #(
    .N_BTNS          (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  btn_debouncer #(
    .N_BTNS          (4),
    .DEBOUNCE_CYCLES (1),
    .CNT_W           (20)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;   // 0 = dut_a, 1 = dut_b
    logic [3:0] eb;
    logic [3:0] ep;
    logic [3:0] er;
    logic       ah;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] got_btns;
  logic [3:0] got_press;
  logic [3:0] got_rel;
  logic       got_ah;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    else
      n_pass++;
  endtask

  // Drive one cycle of stimulus and record what the outputs must be after
  // the rising edge that samples it.
  task automatic step(input bit sel, input logic [3:0] raw, input logic r,
                      input logic [3:0] eb, input logic [3:0] ep,
                      input logic [3:0] er, input string tag);
    exp_t e;
    if (sel) begin
      bus_b.btns_raw = raw;
      rst_b          = r;
    end else begin
      bus_a.btns_raw = raw;
      rst_a          = r;
    end
    e.sel = sel;
    e.eb  = eb;
    e.ep  = ep;
    e.er  = er;
    e.ah  = |eb;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Hold a steady raw level for n edges. The clean level switches from prev
  // to nxt after edge d+2 and the strobes fire for that one cycle only.
  task automatic hold(input bit sel, input logic [3:0] raw, input int n,
                      input int d, input logic [3:0] prev,
                      input logic [3:0] nxt, input string tag);
    for (int e = 1; e <= n; e++) begin
      step(sel, raw, 1'b0,
           (e >= d + 2) ? nxt : prev,
           (e == d + 2) ? (nxt & ~prev) : 4'b0000,
           (e == d + 2) ? (prev & ~nxt) : 4'b0000,
           tag);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.sel) begin
        got_btns  = bus_b.btns;
        got_press = bus_b.press_pulse;
        got_rel   = bus_b.release_pulse;
        got_ah    = bus_b.any_held;
      end else begin
        got_btns  = bus_a.btns;
        got_press = bus_a.press_pulse;
        got_rel   = bus_a.release_pulse;
        got_ah    = bus_a.any_held;
      end
      $display("t=%0t dut_%s %-10s btns=%b press=%b release=%b any_held=%b",
               $time, mon_e.sel ? "b" : "a", mon_e.tag,
               got_btns, got_press, got_rel, got_ah);
      check_val({mon_e.tag, " btns"},     32'(got_btns),  32'(mon_e.eb));
      check_val({mon_e.tag, " press"},    32'(got_press), 32'(mon_e.ep));
      check_val({mon_e.tag, " release"},  32'(got_rel),   32'(mon_e.er));
      check_val({mon_e.tag, " any_held"}, 32'(got_ah),    32'(mon_e.ah));
    end
  end

  initial begin
    logic [3:0] bounce_pat [10];
    bounce_pat = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};

    rst_a          = 1'b1;
    rst_b          = 1'b1;
    bus_a.btns_raw = 4'b0000;
    bus_b.btns_raw = 4'b0000;
    @(negedge clk);
    #1;

    // Reset holds everything low even with all buttons pressed.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 1'b1, 4'h0, 4'h0, 4'h0, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, "idle");

    // Clean press and release on lane 2.
    hold(1'b0, 4'b0100, 10, 4, 4'b0000, 4'b0100, "press2");
    hold(1'b0, 4'b0000, 10, 4, 4'b0100, 4'b0000, "rel2");

    // Bounce on lane 0 never reaches four consecutive disagreeing edges.
    for (int i = 0; i < 10; i++)
      step(1'b0, bounce_pat[i], 1'b0, 4'h0, 4'h0, 4'h0, "bounce0");
    hold(1'b0, 4'b0001, 10, 4, 4'b0000, 4'b0001, "press0");
    hold(1'b0, 4'b0000, 10, 4, 4'b0001, 4'b0000, "rel0");

    // Simultaneous press on lanes 0 and 3.
    hold(1'b0, 4'b1001, 8, 4, 4'b0000, 4'b1001, "simul");
    hold(1'b0, 4'b0000, 8, 4, 4'b1001, 4'b0000, "rel_simul");

    // Reset while lane 1 has counted to 2: count discarded, restart after.
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0, "precount1");
    step(1'b0, 4'b0010, 1'b1, 4'h0, 4'h0, 4'h0, "midreset");
    hold(1'b0, 4'b0010, 8, 4, 4'b0000, 4'b0010, "post_rst");
    hold(1'b0, 4'b0000, 8, 4, 4'b0010, 4'b0000, "rel1");

    // dut_b (DEBOUNCE_CYCLES=1): button held through reset release.
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0010, 1'b1, 4'h0, 4'h0, 4'h0, "b_reset");
    hold(1'b1, 4'b0010, 6, 1, 4'b0000, 4'b0010, "b_held");
    hold(1'b1, 4'b0000, 6, 1, 4'b0010, 4'b0000, "b_rel");

    // Let the monitor drain whatever is still queued, bounded.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check_val("drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Per-button synchroniser, debouncer and edge detector that sits directly upstream of the button interpreter. It takes the raw asynchronous push-button inputs from the board and produces glitch-free button levels, which replace the raw btns bus into btnInterpreter. It also produces single-cycle press and release strobes for sequential consumers such as the speaker trigger and a future game FSM. All buttons are handled by identical, independent lanes.

Parameters:
N_BTNS, 4, number of independent button lanes
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised level must differ from the current clean level before the change is accepted (10 ms at 50 MHz); legal range 1 to 2^CNT_W-1
CNT_W, 20, width of each lane's stability counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
btns_raw  input  N_BTNS  raw asynchronous button levels, 1 = pressed
btns  output  N_BTNS  debounced levels, feeds btnInterpreter btns
press_pulse  output  N_BTNS  one-cycle strobe per lane on an accepted 0->1 change
release_pulse  output  N_BTNS  one-cycle strobe per lane on an accepted 1->0 change
any_held  output  1  OR-reduction of btns, registered-equivalent (combinational from btns only)

Behaviour:
- Reset: when rst=1 at a rising edge, every lane clears: sync_ff1, sync_ff2, btns, press_pulse, release_pulse, cnt all go to 0; any_held=0. rst has priority over every other action. Reset mid-count discards the count, with no pulse.
- Synchroniser: per lane, btns_raw -> sync_ff1 -> sync_ff2 (2 flops). sync_ff2 is the only value used by the lane logic. btns_raw never reaches any output combinationally.
- Lane FSM, evaluated each edge when rst=0:
  - STABLE (sync_ff2 == btns): cnt <= 0; both pulses 0.
  - PENDING (sync_ff2 != btns) and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1; pulses 0.
  - PENDING and cnt == DEBOUNCE_CYCLES-1: btns <= sync_ff2; cnt <= 0. press_pulse <= sync_ff2; release_pulse <= ~sync_ff2.
- Pulses are exactly one clk cycle wide. press_pulse and release_pulse are never both high in the same lane.
- Latency: take edge 1 as the first rising edge at which btns_raw shows the new level, with the level held steady. btns changes after edge DEBOUNCE_CYCLES+2, and the strobe is high for the cycle following that edge. The same holds after reset deassertion with a button already held: edge 1 is the first edge with rst=0.
- Glitch rejection: if sync_ff2 returns to equal btns before the count completes, cnt resets to 0 and nothing changes. A later disagreement restarts the count from 0. There is no hysteresis beyond this.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Lanes are fully independent. Simultaneous changes on several lanes produce simultaneous pulses. There is no priority; priority resolution stays in btnInterpreter.
- DEBOUNCE_CYCLES=1 is legal: acceptance happens on the first PENDING edge, giving latency 3 edges.

Test Plan:
- Reset: drive btns_raw=4'b1111 with rst=1 for 5 cycles -> btns=0, both pulse buses=0, any_held=0 throughout.
- Clean press, DEBOUNCE_CYCLES=4: btns_raw[2] 0->1 held -> btns[2] rises after edge 6; press_pulse=4'b0100 for exactly 1 cycle; other lanes stay 0. Release later -> release_pulse=4'b0100 for 1 cycle, 6 edges after the change.
- Bounce, DEBOUNCE_CYCLES=4: toggle btns_raw[0] high 3 cycles, low 1, high 3, low -> btns[0] stays 0 and no pulses. Then hold high 10 cycles -> exactly one press_pulse[0].
- Simultaneous, DEBOUNCE_CYCLES=4: btns_raw 0000->1001 on the same edge -> press_pulse=1001 in one cycle, btns=1001, any_held=1.
- Reset mid-count: raise btns_raw[1], assert rst for 1 cycle at count 2 -> no pulse. Count restarts and btns[1] rises 6 edges after rst deasserts.
- Held through reset, DEBOUNCE_CYCLES=1: btns_raw=4'b0010 held, rst released -> btns[1] rises after edge 3 with press_pulse[1] for 1 cycle.
